// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the byte-wide instruction memory port between the boot loader and the
// fetch stage. A fetch assembles a little-endian 16-bit instruction from two byte reads.
module imem_fetch_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  output logic              fetch_busy,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       fetch_count
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, DONE} state_e;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        lo_q, lo_d;
  logic              fault_q, fault_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              ld_error_q, ld_error_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      lo_q          <= '0;
      fault_q       <= 1'b0;
      instr_q       <= '0;
      fetch_count_q <= '0;
      ld_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      lo_q          <= lo_d;
      fault_q       <= fault_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      ld_error_q    <= ld_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    lo_d          = lo_q;
    fault_d       = fault_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    ld_error_d    = 1'b0;
    mem_addr      = addr_q;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = ld_data;
    ld_ready      = 1'b0;

    unique case (state_q)
      IDLE: begin
        ld_ready = 1'b1;
        // Loader has absolute priority; its write goes straight through this cycle.
        if (ld_valid) begin
          mem_addr = ld_addr;
          if (ld_addr < DEPTH_A) mem_we     = 1'b1;
          else                   ld_error_d = 1'b1;
        end else if (fetch_req) begin
          addr_d = fetch_addr;
          if (fetch_addr > LAST_A) begin
            fault_d       = 1'b1;
            lo_d          = '0;
            instr_d       = '0;
            fetch_count_d = fetch_count_q + 16'd1;
            state_d       = DONE;
          end else begin
            fault_d = 1'b0;
            state_d = RD_LO;
          end
        end
      end
      RD_LO: begin
        mem_re  = 1'b1;
        state_d = RD_HI;
      end
      RD_HI: begin
        mem_re   = 1'b1;
        mem_addr = addr_q + ADDR_W'(1);
        lo_d     = mem_rdata;
        state_d  = CAP;
      end
      CAP: begin
        // High byte arrives now; assemble directly so instr changes only entering DONE.
        instr_d       = {mem_rdata, lo_q};
        fetch_count_d = fetch_count_q + 16'd1;
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (reset) begin
      ld_ready = 1'b0;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = (state_q == DONE);
  assign fetch_fault = (state_q == DONE) && fault_q;
  assign fetch_busy  = (state_q != IDLE);
  assign ld_error    = ld_error_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a cycle-level reference model of the
// fetch/loader protocol and a small synchronous byte memory.
module tb_imem_fetch_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, fetch_req, ld_valid;
  logic [15:0] fetch_addr, ld_addr;
  logic [7:0]  ld_data;
  logic [15:0] instr, mem_addr, fetch_count;
  logic        instr_valid, fetch_fault, fetch_busy, ld_ready, ld_error;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  tbmem [0:63];

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.ADDR_W(16), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .fetch_busy(fetch_busy), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_error(ld_error),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fetch_count(fetch_count)
  );

  always @(posedge clk) begin
    if (mem_we) tbmem[mem_addr[5:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= tbmem[mem_addr[5:0]];
  end

  // Reference model: k = cycles since a fetch was accepted (-1 when idle).
  int          k;
  logic [15:0] ma;
  bit          mf;
  logic [7:0]  mmem [0:63];
  logic [15:0] mcnt, minstr;
  bit          merr;
  bit          model_on;
  int          n_cmp, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit          done, ere, ewe, erdy;
    logic [15:0] a1;
    done = (k >= 0) && (k == (mf ? 0 : 3));
    erdy = !reset && (k < 0);
    ewe  = erdy && ld_valid && (ld_addr < DEPTH);
    ere  = !reset && !mf && (k == 0 || k == 1);
    chk("ld_ready", ld_ready, erdy);
    chk("mem_we", mem_we, ewe);
    chk("mem_re", mem_re, ere);
    chk("instr_valid", instr_valid, done);
    chk("fetch_fault", fetch_fault, done && mf);
    chk("fetch_busy", fetch_busy, k >= 0);
    chk("instr", instr, minstr);
    chk("fetch_count", fetch_count, mcnt);
    chk("ld_error", ld_error, merr);
    if (ere) chk("mem_addr_rd", mem_addr, ma + 16'(k));
    if (ewe) begin
      chk("mem_addr_wr", mem_addr, ld_addr);
      chk("mem_wdata", mem_wdata, ld_data);
    end
    if (reset) begin
      k = -1; minstr = 16'h0; mcnt = 16'h0; merr = 1'b0;
    end else begin
      merr = (k < 0) && ld_valid && (ld_addr >= DEPTH);
      if (k < 0) begin
        if (ld_valid) begin
          if (ld_addr < DEPTH) mmem[ld_addr[5:0]] = ld_data;
        end else if (fetch_req) begin
          ma = fetch_addr;
          mf = (fetch_addr > DEPTH - 2);
          k  = 0;
          if (mf) begin minstr = 16'h0; mcnt = mcnt + 16'd1; end
        end
      end else if (done) begin
        k = -1;
      end else begin
        k++;
        if (k == 3) begin
          a1     = ma + 16'd1;
          minstr = {mmem[a1[5:0]], mmem[ma[5:0]]};
          mcnt   = mcnt + 16'd1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_on) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    if (!instr_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] ld_vec [0:5];
  int         n;

  initial begin
    ld_vec = '{8'h00, 8'h00, 8'h08, 8'h6A, 8'h08, 8'hAB};
    reset = 1'b1; fetch_req = 1'b0; ld_valid = 1'b0;
    fetch_addr = '0; ld_addr = '0; ld_data = '0;
    k = -1; ma = '0; mf = 1'b0; mcnt = '0; minstr = '0; merr = 1'b0;
    model_on = 1'b0; n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) mmem[i] = 8'h00;

    tick();
    model_on = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_instr", instr, 16'h0);
    chk("rst_count", fetch_count, 16'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_busy", fetch_busy, 1'b0);

    // Back-to-back loader writes of the program image.
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_addr = 16'(i); ld_data = ld_vec[i];
      #1;
      chk("load_ready", ld_ready, 1'b1);
      chk("load_we", mem_we, 1'b1);
      tick();
    end
    ld_valid = 1'b0;
    chk("load_err", ld_error, 1'b0);

    // Reset during CAP aborts the fetch.
    fetch_req = 1'b1; fetch_addr = 16'd2;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    chk("cap_busy", fetch_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", instr_valid, 1'b0);
    chk("abort_count", fetch_count, 16'h0);
    chk("abort_busy", fetch_busy, 1'b0);
    tick();
    tick();

    // Plain fetch at address 2.
    fetch_req = 1'b1; fetch_addr = 16'd2;
    tick();
    wait_valid(n);
    chk("lat_fetch2", 32'(n), 32'd3);
    chk("instr_fetch2", instr, 16'h6A08);
    chk("fault_fetch2", fetch_fault, 1'b0);
    chk("count_fetch2", fetch_count, 16'd1);
    fetch_req = 1'b0;
    tick();

    // Loader and fetch requested together: loader first.
    ld_valid = 1'b1; ld_addr = 16'd10; ld_data = 8'h5C;
    fetch_req = 1'b1; fetch_addr = 16'd4;
    #1;
    chk("cont_we", mem_we, 1'b1);
    tick();
    ld_valid = 1'b0;
    chk("cont_idle", fetch_busy, 1'b0);
    tick();
    chk("cont_busy", fetch_busy, 1'b1);
    chk("cont_re", mem_re, 1'b1);
    chk("cont_addr", mem_addr, 16'd4);
    tick();
    ld_valid = 1'b1; ld_addr = 16'd11; ld_data = 8'h77;
    #1;
    chk("rdhi_ready", ld_ready, 1'b0);
    wait_valid(n);
    chk("lat_cont", 32'(n), 32'd2);
    chk("instr_cont", instr, 16'hAB08);
    chk("done_ready", ld_ready, 1'b0);
    fetch_req = 1'b0;
    tick();
    chk("after_ready", ld_ready, 1'b1);
    chk("after_we", mem_we, 1'b1);
    tick();
    ld_valid = 1'b0;

    // Out-of-range fetch.
    fetch_req = 1'b1; fetch_addr = 16'd63;
    tick();
    chk("flt_valid", instr_valid, 1'b1);
    chk("flt_fault", fetch_fault, 1'b1);
    chk("flt_instr", instr, 16'h0);
    chk("flt_re", mem_re, 1'b0);
    chk("flt_count", fetch_count, 16'd3);
    fetch_req = 1'b0;
    tick();
    chk("flt_after", instr_valid, 1'b0);

    // Out-of-range loader write.
    ld_valid = 1'b1; ld_addr = 16'd64; ld_data = 8'hEE;
    #1;
    chk("ldbad_we", mem_we, 1'b0);
    chk("ldbad_ready", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    chk("ldbad_err", ld_error, 1'b1);
    tick();
    chk("ldbad_err_clr", ld_error, 1'b0);

    // fetch_req dropped in RD_LO still completes.
    fetch_req = 1'b1; fetch_addr = 16'd10;
    tick();
    fetch_req = 1'b0;
    wait_valid(n);
    chk("drop_lat", 32'(n), 32'd3);
    chk("drop_instr", instr, 16'h775C);
    chk("drop_count", fetch_count, 16'd4);
    tick();

    // Held request starts a new fetch right after DONE.
    fetch_req = 1'b1; fetch_addr = 16'd2;
    tick();
    wait_valid(n);
    tick();
    chk("b2b_idle", fetch_busy, 1'b0);
    tick();
    chk("b2b_busy", fetch_busy, 1'b1);
    wait_valid(n);
    chk("b2b_instr", instr, 16'h6A08);
    chk("b2b_count", fetch_count, 16'd6);
    fetch_req = 1'b0;
    tick();

    // Highest in-range address.
    fetch_req = 1'b1; fetch_addr = 16'd62;
    tick();
    fetch_req = 1'b0;
    wait_valid(n);
    chk("edge_fault", fetch_fault, 1'b0);
    chk("edge_instr", instr, 16'h0000);
    tick();

    // Counter wrap.
    force dut.fetch_count_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    tick();
    release dut.fetch_count_q;
    chk("wrap_preset", fetch_count, 16'hFFFE);
    fetch_req = 1'b1; fetch_addr = 16'h0100;
    tick();
    chk("wrap_ffff", fetch_count, 16'hFFFF);
    fetch_req = 1'b0;
    tick();
    fetch_req = 1'b1;
    tick();
    chk("wrap_zero", fetch_count, 16'h0000);
    fetch_req = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Sequencer and arbiter for the single-port, byte-wide instruction memory of the multi-cycle processor. It assembles 16-bit little-endian instructions from two consecutive byte reads for the fetch stage. It also shares the same memory port with a boot-time program loader that writes bytes. The block sits between the control unit's fetch request (PC) and the byte memory array.

## Interface
Parameters:
- ADDR_W, 16, width of all byte addresses
- MEM_DEPTH, 64, number of bytes in the memory; valid byte addresses are 0..MEM_DEPTH-1

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request (level); sampled only in IDLE
- fetch_addr  in  ADDR_W  byte address of the instruction (PC); latched on accept
- instr  out  16  assembled instruction {mem[a+1], mem[a]}; held between fetches
- instr_valid  out  1  one-cycle pulse, instr valid this cycle
- fetch_fault  out  1  pulses with instr_valid when the fetch address was out of range
- fetch_busy  out  1  high while state != IDLE
- ld_valid  in  1  loader byte-write request
- ld_addr  in  ADDR_W  loader byte address
- ld_data  in  8  loader byte
- ld_ready  out  1  loader handshake; write occurs when ld_valid && ld_ready
- ld_error  out  1  one-cycle pulse, accepted loader write dropped (address >= MEM_DEPTH)
- mem_addr  out  ADDR_W  memory byte address
- mem_re  out  1  memory read enable; mem_rdata valid the following cycle
- mem_we  out  1  memory write enable, writes mem_wdata at mem_addr on this edge
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte (synchronous read, 1-cycle latency)
- fetch_count  out  16  number of completed fetches, including faulted ones

## Operation
- FSM states: IDLE, RD_LO, RD_HI, CAP, DONE.
- IDLE, ld_valid=1: the loader wins with absolute priority. ld_ready=1, and the write is performed combinationally in the same cycle: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data. If ld_addr >= MEM_DEPTH, mem_we=0 and ld_error pulses next cycle. The FSM stays in IDLE.
- IDLE, ld_valid=0, fetch_req=1: the fetch is accepted and a=fetch_addr is latched.
  - If a > MEM_DEPTH-2, set the fault flag, clear the captured bytes, and go to DONE.
  - Otherwise go to RD_LO.
- RD_LO: mem_re=1, mem_addr=a. Next state RD_HI.
- RD_HI: mem_re=1, mem_addr=a+1 (ADDR_W-bit add). lo <= mem_rdata. Next state CAP.
- CAP: hi <= mem_rdata. Next state DONE.
- DONE: instr_valid=1, instr={hi,lo} (16'h0000 on a fault), fetch_fault=fault flag, fetch_count increments (wraps 16'hFFFF->0). Next state IDLE.
- ld_ready=0 in every state except IDLE. The loader stalls during a fetch and a fetch is never preempted.
- Once accepted, a fetch always completes even if fetch_req drops. fetch_req is ignored outside IDLE.
- The requester holds fetch_req until instr_valid. A fetch_req still high in the cycle after DONE starts a new fetch.
- With continuous ld_valid, fetches starve. This is intended: loading happens only before the CPU is released.
- mem_re and mem_we are never high in the same cycle.

## Timing
- Reset (sampled high at an edge): state=IDLE, instr=0, instr_valid=0, fetch_fault=0, ld_error=0, fetch_count=0, lo/hi=0.
- While reset is high: ld_ready=0, mem_we=0, mem_re=0.
- Reset mid-fetch aborts the fetch with no instr_valid. Reset in the same cycle as a loader handshake suppresses the write.
- Normal fetch: accepted at edge T (IDLE); RD_LO during T..T+1; instr_valid high during cycle T+4. Throughput is one fetch per 5 cycles.
- Faulted fetch: instr_valid and fetch_fault high during cycle T+1 (2-cycle turnaround).
- Loader: one byte per cycle while in IDLE. ld_error is registered and pulses the cycle after the dropped write.
- instr, fetch_count: registered, updated on the edge entering DONE. instr holds its value afterward.

## Test plan
- Reset then load: write mem[0..5] = 00,00,08,6A,08,AB via the loader with back-to-back ld_valid. Require ld_ready=1 in each cycle, 6 mem_we pulses, and no ld_error.
- Fetch at addr 2: require mem_re at addr 2 then addr 3, and instr=16'h6A08 with instr_valid exactly 4 cycles after accept, fetch_fault=0, fetch_count=1.
- Contention: assert ld_valid and fetch_req in the same IDLE cycle (addr 4). Require the loader write first, the fetch accepted the next cycle, and instr=16'hAB08. Then assert ld_valid during RD_HI: require ld_ready=0 until back in IDLE.
- Faults: fetch at addr 63 with MEM_DEPTH=64: require instr=0, fetch_fault=1, instr_valid 1 cycle after accept, and no mem_re. Loader write to addr 64: require mem_we=0 and an ld_error pulse.
- fetch_req dropped in RD_LO: require the fetch to complete with instr_valid. Reset asserted in CAP: require no instr_valid, all outputs at reset values, and fetch_count unchanged from before the aborted fetch.
- Counter wrap: preset via 65536 fetches (or force). Require fetch_count to go 16'hFFFF -> 16'h0000.
